// File: rtl/tcam_rule_writer_pkg.sv
// Shared definitions for the TCAM rule writer: FSM encoding and SRL geometry.
// The TCAM stores each rule as 5-bit slices held in 32-deep shift-register LUTs.
package tcam_rule_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int SRL_DEPTH       = 32;
    localparam int SLICE_W         = 5;
    localparam int RULES_PER_GROUP = 8;
    localparam int CNT_W           = $clog2(SRL_DEPTH);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SRL_DEPTH - 1);

endpackage

// File: rtl/tcam_rule_writer_slice_match_gen.sv
// One SRL content bit: does SRL address cnt match this rule's 5-bit value
// under its care mask (care bit 0 = don't-care)?
module slice_match_gen
    import tcam_rule_writer_pkg::*;
(
    input  logic [SLICE_W-1:0] cnt,
    input  logic [SLICE_W-1:0] value,
    input  logic [SLICE_W-1:0] care,
    output logic               match
);

    assign match = (((cnt ^ value) & care) == '0);

endmodule

// File: rtl/tcam_rule_writer.sv
// Programs one 8-rule group of an SRL-based TCAM by shifting 32 precomputed
// match bits per slice, address 31 first, so address k ends holding key k.
module tcam_rule_writer
    import tcam_rule_writer_pkg::*;
#(
    parameter int W = 20,
    parameter int D = 64
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [$clog2(D/RULES_PER_GROUP)-1:0]  req_group,
    input  logic [RULES_PER_GROUP*W-1:0]          req_value,
    input  logic [RULES_PER_GROUP*W-1:0]          req_care,
    output logic [D/RULES_PER_GROUP-1:0]          we,
    output logic [W*RULES_PER_GROUP/SLICE_W-1:0]  rules,
    output logic                                  busy,
    output logic                                  done,
    output state_t                                dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the requester holds req_valid and data stable until that edge.

    localparam int GW    = D / RULES_PER_GROUP;
    localparam int GRP_W = $clog2(GW);
    localparam int NS    = W / SLICE_W;
    localparam int RW    = NS * RULES_PER_GROUP;
    localparam int VW    = RULES_PER_GROUP * W;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [GRP_W-1:0]   grp_q;
    logic [VW-1:0]      value_q;
    logic [VW-1:0]      care_q;

    logic [CNT_W-1:0]   nxt_cnt;
    logic [VW-1:0]      sel_value;
    logic [VW-1:0]      sel_care;
    logic [RW-1:0]      match_nxt;

    // Match bits are computed for the cycle about to start so rules can be registered.
    always_comb begin
        nxt_cnt   = cnt - CNT_W'(1);
        sel_value = value_q;
        sel_care  = care_q;
        if (state == ST_IDLE) begin
            nxt_cnt   = CNT_MAX;
            sel_value = req_value;
            sel_care  = req_care;
        end
    end

    for (genvar i = 0; i < NS; i++) begin : g_slice
        for (genvar j = 0; j < RULES_PER_GROUP; j++) begin : g_rule
            slice_match_gen u_match (
                .cnt   (nxt_cnt),
                .value (sel_value[j*W + i*SLICE_W +: SLICE_W]),
                .care  (sel_care [j*W + i*SLICE_W +: SLICE_W]),
                .match (match_nxt[i*RULES_PER_GROUP + j])
            );
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= CNT_MAX;
            grp_q   <= '0;
            value_q <= '0;
            care_q  <= '0;
            we      <= '0;
            rules   <= '0;
            done    <= 1'b0;
        end else begin
            we    <= '0;
            rules <= '0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        grp_q   <= req_group;
                        value_q <= req_value;
                        care_q  <= req_care;
                        cnt     <= CNT_MAX;
                        we      <= GW'(1) << req_group;
                        rules   <= match_nxt;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt   <= nxt_cnt;
                        we    <= GW'(1) << grp_q;
                        rules <= match_nxt;
                    end
                end
                ST_DONE: begin
                    cnt   <= CNT_MAX;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign req_ready = ~busy;
    assign dbg_state = state;

endmodule

// File: tb/tb_tcam_rule_writer.sv
// Directed bench for tcam_rule_writer: exact/wildcard rule encoding, handshake,
// abort by reset, and an end-to-end lookup through a behavioural SRL TCAM.
module tb_tcam_rule_writer;
    import tcam_rule_writer_pkg::*;

    localparam int W  = 20;
    localparam int D  = 64;
    localparam int VW = 8 * W;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [2:0]     req_group = '0;
    logic [VW-1:0]  req_value = '0;
    logic [VW-1:0]  req_care = '0;
    logic [7:0]     we;
    logic [31:0]    rules;
    logic           busy;
    logic           done;
    state_t         dbg_state;

    int checks = 0;
    int errors = 0;

    // behavioural TCAM for group 0: srl[slice][rule], bit k = SRL address k
    logic [31:0] srl [4][8];

    tcam_rule_writer #(.W(W), .D(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_group (req_group),
        .req_value (req_value),
        .req_care  (req_care),
        .we        (we),
        .rules     (rules),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we[0]) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 8; j++)
                    srl[i][j] <= {srl[i][j][30:0], rules[i*8+j]};
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (we !== 8'h00 || rules !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: we=%h rules=%h busy=%b done=%b ready=%b, want 00 00000000 0 0 1",
                     we, rules, busy, done, req_ready);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d want %0d", dbg_state, ST_IDLE);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (we !== 8'h00 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: we=%h busy=%b ready=%b, want 00 0 1", we, busy, req_ready);
        end
    endtask

    task automatic test_exact_rule();
        int s0 [4];
        int cnt;
        logic [31:0] exp;
        s0 = '{5, 26, 8, 2};
        req_group = 3'd2;
        req_value = '0;
        req_value[19:0] = 20'h12345;
        req_care = '1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            cnt = 31 - k;
            exp = '0;
            for (int i = 0; i < 4; i++) begin
                if (cnt == s0[i]) exp[i*8] = 1'b1;
                if (cnt == 0) exp[i*8+1 +: 7] = 7'h7f;
            end
            checks++;
            if (we !== 8'b0000_0100 || busy !== 1'b1) begin
                errors++;
                $display("FAIL exact_we: cnt=%0d we=%b busy=%b, want 00000100 1", cnt, we, busy);
            end
            checks++;
            if (rules !== exp) begin
                errors++;
                $display("FAIL exact_rules: cnt=%0d rules=%h want %h", cnt, rules, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || we !== 8'h00 || rules !== 32'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL exact_done: done=%b we=%h rules=%h busy=%b, want 1 00 0 1", done, we, rules, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL exact_idle: done=%b ready=%b busy=%b, want 0 1 0", done, req_ready, busy);
        end
    endtask

    task automatic test_wildcard();
        int s0 [4];
        int cnt;
        logic [31:0] exp;
        s0 = '{5, 26, 8, 2};
        req_group = 3'd4;
        req_value = '0;
        req_care = '1;
        req_value[0*W +: W] = 20'h12345;
        req_value[3*W +: W] = 20'hABCDE;
        req_care [3*W +: W] = 20'h00000;
        req_value[5*W +: W] = 20'h00007;
        req_care [5*W +: W] = 20'h0001F;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            cnt = 31 - k;
            exp = '0;
            for (int i = 0; i < 4; i++) begin
                if (cnt == s0[i]) exp[i*8] = 1'b1;
                for (int j = 1; j < 8; j++)
                    if (cnt == 0) exp[i*8+j] = 1'b1;
                exp[i*8+3] = 1'b1;
                exp[i*8+5] = (i == 0) ? (cnt == 7) : 1'b1;
            end
            checks++;
            if (we !== 8'b0001_0000) begin
                errors++;
                $display("FAIL wild_we: cnt=%0d we=%b want 00010000", cnt, we);
            end
            checks++;
            if (rules !== exp) begin
                errors++;
                $display("FAIL wild_rules: cnt=%0d rules=%h want %h", cnt, rules, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || we !== 8'h00) begin
            errors++;
            $display("FAIL wild_done: done=%b we=%h want 1 00", done, we);
        end
        @(negedge clk);
    endtask

    task automatic test_end_to_end();
        logic [19:0] sk;
        logic m0, m1, m2;
        logic [19:0] keys [2];
        logic exp0 [2];
        keys = '{20'h12345, 20'h12344};
        exp0 = '{1'b1, 1'b0};
        req_group = 3'd0;
        req_value = {8{20'hFFFFF}};
        req_care  = {8{20'hFFFFF}};
        req_value[0*W +: W] = 20'h12345;
        req_care [2*W +: W] = 20'h00000;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (33) @(negedge clk);
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            sk = keys[n];
            m0 = 1'b1; m1 = 1'b1; m2 = 1'b1;
            for (int i = 0; i < 4; i++) begin
                m0 &= srl[i][0][sk[i*5 +: 5]];
                m1 &= srl[i][1][sk[i*5 +: 5]];
                m2 &= srl[i][2][sk[i*5 +: 5]];
            end
            checks++;
            if (m0 !== exp0[n] || m1 !== 1'b0 || m2 !== 1'b1) begin
                errors++;
                $display("FAIL e2e_match: sk=%h match[2:0]=%b%b%b want %b%b%b",
                         sk, m2, m1, m0, 1'b1, 1'b0, exp0[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        req_group = 3'd5;
        req_value = '0;
        req_care = '1;
        req_valid = 1'b1;
        @(negedge clk);
        req_group = 3'd1;
        req_value[19:0] = 20'h00003;
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (we !== 8'b0010_0000 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_first: k=%0d we=%b ready=%b want 00100000 0", k, we, req_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || req_ready !== 1'b0 || we !== 8'h00) begin
            errors++;
            $display("FAIL b2b_done1: done=%b ready=%b we=%h want 1 0 00", done, req_ready, we);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || we !== 8'h00) begin
            errors++;
            $display("FAIL b2b_idle: ready=%b we=%h want 1 00", req_ready, we);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            cnt = 31 - k;
            checks++;
            if (we !== 8'b0000_0010 || rules[0] !== (cnt == 3)) begin
                errors++;
                $display("FAIL b2b_second: cnt=%0d we=%b rules0=%b want 00000010 %b", cnt, we, rules[0], cnt == 3);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done2: done=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic saw_done;
        int cyc;
        req_group = 3'd3;
        req_value = '0;
        req_care = '1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (21) @(negedge clk);
        checks++;
        if (we !== 8'b0000_1000) begin
            errors++;
            $display("FAIL abort_pre: we=%b want 00001000", we);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (we !== 8'h00 || rules !== 32'h0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_now: we=%h rules=%h busy=%b ready=%b want 00 0 0 1", we, rules, busy, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || we !== 8'h00) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: activity after abort=%b want 0", saw_done);
        end
        req_group = 3'd6;
        req_valid = 1'b1;
        cyc = 0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 33) begin
            errors++;
            $display("FAIL abort_retry_latency: done after %0d cycles want 33", cyc);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_exact_rule();
        test_wildcard();
        test_end_to_end();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcam_rule_writer.md
TCAM_RULE_WRITER -- requirements
Module: tcam_rule_writer

Interface
REQ-001 SHALL have parameter W, default 20: search-key width in bits; a multiple of 5.
REQ-002 SHALL have parameter D, default 64: TCAM depth in rules; a multiple of 8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: a group-write request is presented.
REQ-006 SHALL have port req_ready, output, 1 bit: the writer can accept a request.
REQ-007 SHALL have port req_group, input, log2(D/8) bits: index of the 8-rule group to program.
REQ-008 SHALL have port req_value, input, 8*W bits: rule j value at bits [j*W+W-1:j*W].
REQ-009 SHALL have port req_care, input, 8*W bits: rule j care mask, same packing; 1 = compare, 0 = don't-care.
REQ-010 SHALL have port we, output, D/8 bits: one-hot shift-enable per group, to the TCAM we input.
REQ-011 SHALL have port rules, output, W*8/5 bits: slice i, rule j bit at index i*8+j, to the TCAM rules input.
REQ-012 SHALL have port busy, output, 1 bit: a programming sequence is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: req_ready=1; on req_valid&&req_ready, SHALL capture group, value and care into registers, set cnt=31, and go to SHIFT.
REQ-016 SHIFT: SHALL last exactly 32 cycles, with cnt stepping 31,30,...,0 (one step per cycle).
REQ-017 SHIFT, each cycle: we SHALL be one-hot at bit captured_group; all other we bits 0.
REQ-018 SHIFT, rules[i*8+j] SHALL be 1 iff ((cnt XOR value_j[i*5+4:i*5]) AND care_j[i*5+4:i*5]) == 0.
REQ-019 Shift order (cnt 31 first, 0 last) SHALL leave the bit for key value k at SRL address k after 32 shifts.
REQ-020 SHIFT at cnt=0: SHALL go to DONE next cycle.
REQ-021 DONE: SHALL hold for one cycle with done=1, we=0, then return to IDLE.
REQ-022 Every cycle outside SHIFT: we SHALL be 0 and rules SHALL be 0.
REQ-023 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE; req_ready SHALL equal NOT busy.
REQ-024 Requests during busy SHALL not be accepted; the requester holds req_valid/data until accepted.
REQ-025 Captured registers SHALL be stable during SHIFT; changes on req_* inputs there have no effect.
REQ-026 An out-of-range req_group (>= D/8) SHALL never occur, since req_group width is exactly log2(D/8).
REQ-027 Accept-to-first-we latency SHALL be 1 cycle; accept-to-done SHALL be 33 cycles.
REQ-028 Back-to-back requests SHALL be accepted in the IDLE cycle after DONE, giving 34 cycles per group.

Reset
REQ-029 While reset=1: state SHALL be IDLE, cnt=31, captured registers 0, we=0, rules=0, busy=0, done=0, req_ready=1.
REQ-030 Reset mid-SHIFT SHALL abort at once: we drops to 0 asynchronously and no done pulse follows; the partially shifted group is invalid and must be rewritten.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding, SRL_DEPTH=32, SLICE_W=5 and RULES_PER_GROUP=8.
REQ-032 The rule-bit compare SHALL be one sub-module, slice_match_gen, instantiated per slice and per rule (generate loop over n=W/5 slices and 8 rules).
REQ-033 Outputs we and rules SHALL be registered, so they drive the TCAM glitch-free.

Verification
REQ-034 Reset: reset held 3 cycles -> we=0, rules=0, busy=0, req_ready=1.
REQ-035 Exact rule: group=2; rule0 value=20'h12345, care=20'hFFFFF; others care=all-ones, value=0 -> we=8'b00000100 for 32 cycles; rules[0] (slice0) =1 only at cnt=5; slice1 bit =1 only at cnt=(0x12345>>5)&31=26; done pulses at cycle 33.
REQ-036 Wildcard: rule3 care=0 -> rules[i*8+3]=1 on all 32 SHIFT cycles for every slice.
REQ-037 End-to-end: program group 0 via frac_tcam, then search sk=20'h12345 -> match[0]=1; sk=20'h12344 -> match[0]=0.
REQ-038 Busy handshake: second req_valid asserted during SHIFT -> req_ready=0 and no capture; accepted the cycle after done; we shows a one-hot group for 32 consecutive cycles both times.
REQ-039 Abort: reset asserted at cnt=10 -> we=0 immediately, no done; a subsequent request completes normally.
